// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter: round-robin between ALU (A) and load (B)
// writebacks, one registered write slot per cycle, plus a saturating conflict counter.
module regwrite_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [31:0]       dselect,
  output logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic              last_grant_q, last_grant_d;
  logic [31:0]       dselect_q, dselect_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              conflict;

  // Handshake: a request is accepted at a posedge when valid and ready are both high;
  // ready depends only on valid, hold, reset and the last grant, never on the bank.
  assign conflict = a_valid & b_valid & ~hold;
  assign a_ready  = rst_n & ~hold & a_valid & (~b_valid | (last_grant_q == GRANT_B));
  assign b_ready  = rst_n & ~hold & b_valid & (~a_valid | (last_grant_q == GRANT_A));

  always_comb begin
    last_grant_d = last_grant_q;
    wdata_d      = wdata_q;
    dselect_d    = '0;
    cnt_d        = cnt_q;
    if (a_ready) begin
      dselect_d    = (a_addr == 5'd0) ? 32'd0 : (32'd1 << a_addr);
      wdata_d      = a_data;
      last_grant_d = GRANT_A;
    end else if (b_ready) begin
      dselect_d    = (b_addr == 5'd0) ? 32'd0 : (32'd1 << b_addr);
      wdata_d      = b_data;
      last_grant_d = GRANT_B;
    end
    if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Reset leaves last_grant at B so that A wins the first conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_B;
      dselect_q    <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      dselect_q    <= dselect_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dselect      = dselect_q;
  assign wdata        = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of write data.
REQ-002 SHALL have parameter CNT_W, default 8: width of the conflict counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port hold, input, 1: pipeline freeze; blocks all grants while high.
REQ-006 SHALL have port a_valid, input, 1: requester A (ALU writeback) has a write pending.
REQ-007 SHALL have port a_addr, input, 5: destination register index for A.
REQ-008 SHALL have port a_data, input, DATA_W: write data for A.
REQ-009 SHALL have port a_ready, output, 1: A's request is accepted this cycle.
REQ-010 SHALL have ports b_valid, b_addr, b_data, and b_ready, with the same directions and widths as A's, for requester B (load writeback).
REQ-011 SHALL have port dselect, output, 32: one-hot register write select for the register-file bank.
REQ-012 SHALL have port wdata, output, DATA_W: register-file write data bus.
REQ-013 SHALL have port conflict_cnt, output, CNT_W: count of cycles in which A and B were both valid and hold was low.

Function
REQ-014 SHALL accept a request on posedge N when valid&ready are both high at that edge; ready SHALL be combinational from valid, hold and last_grant.
REQ-015 SHALL drive a_ready=b_ready=0 while hold=1, regardless of valid.
REQ-016 With hold=0, SHALL grant A when only A is valid, and SHALL grant B when only B is valid.
REQ-017 With hold=0 and both valid, SHALL grant the requester not granted most recently (round-robin), and the loser's ready SHALL be 0.
REQ-018 SHALL assert at most one of a_ready/b_ready in any cycle.
REQ-019 SHALL update last_grant only on an accepted request; idle and hold cycles leave it unchanged.
REQ-020 On acceptance at posedge N, SHALL register dselect=1<<addr and wdata=data at posedge N and hold both stable until posedge N+1, so the bank's negedge capture between N and N+1 sees stable values.
REQ-021 The latency from acceptance to dselect visibility SHALL be one registered stage, with one write slot per cycle and back-to-back writes every cycle.
REQ-022 SHALL clear dselect to 0 at the posedge following any cycle with no acceptance; wdata SHALL then hold its last value.
REQ-023 An accepted request with addr=0 SHALL complete the handshake (ready=1), SHALL drive dselect=0, and SHALL still update wdata and last_grant.
REQ-024 When A and B target the same address in the same cycle, SHALL write only the granted requester that cycle; the loser SHALL be written on a later grant, never merged.
REQ-025 SHALL increment conflict_cnt by 1 on each posedge where a_valid&b_valid&!hold, saturating at 2^CNT_W-1 with no wrap-around.
REQ-026 SHALL produce dselect as exactly one-hot or all-zero in every cycle.

Reset
REQ-027 With rst_n=0 at a posedge, SHALL set dselect=0, wdata=0, conflict_cnt=0, and last_grant=B so that A wins the first conflict.
REQ-028 While rst_n=0, SHALL drive a_ready=b_ready=0 and accept no request.
REQ-029 SHALL drop a reset asserted mid-operation, including the slot in progress: dselect SHALL be 0 from that posedge onward, and no pending request SHALL be remembered.
REQ-030 SHALL make the first acceptance possible at the first posedge with rst_n=1.

Verification
REQ-031 The bench SHALL cover a single-requester write: A valid with addr=5 and data=0xDEADBEEF -> a_ready=1; dselect=0x00000020 and wdata=0xDEADBEEF for exactly one cycle, then dselect=0.
REQ-032 The bench SHALL cover round-robin ordering: after reset, A and B both held valid for 4 cycles -> grants A,B,A,B; conflict_cnt=4; dselect alternates between a_addr and b_addr one-hot.
REQ-033 The bench SHALL cover hold behaviour: hold=1 with both valid -> both ready=0, dselect=0, conflict_cnt unchanged; releasing hold -> grant goes to the requester after the last granted one.
REQ-034 The bench SHALL cover an r0 write: B valid with addr=0 and data=0x1234 -> b_ready=1, dselect=0, wdata=0x1234.
REQ-035 The bench SHALL cover counter saturation: with CNT_W=2 and 6 conflict cycles -> conflict_cnt reaches 3 and stays at 3.
REQ-036 The bench SHALL cover reset mid-write: rst_n low on the posedge after an acceptance -> dselect=0, conflict_cnt=0; with both valid after release -> A granted first.
